mw_wb_stage: RTL and testbench

//   M/W pipeline register plus write-back logic for the 5-stage MIPS core.
//   - Captures the memory-stage result: ALU value, DM read word, link PC, rd, control.
//   - Produces the grf write port: WE, A3, WD and pc for the write trace.
//   - Exports the same write as the W-stage forwarding source.
//   - Counts retired instructions.

---
 rtl/mw_wb_stage.sv | 112 +++++++++++
 tb/tb_mw_wb_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mw_wb_stage.sv
// M/W pipeline register and write-back mux for the 5-stage MIPS core.
// Optional sub-word load extension is enabled by defining WB_LOAD_EXT_EN.
module mw_wb_stage #(
   parameter logic [31:0] PC_LINK_OFS = 32'd8,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             m_valid,
   input  logic [31:0]      m_pc,
   input  logic             m_reg_we,
   input  logic [4:0]       m_rd,
   input  logic [1:0]       m_wd_sel,
   input  logic [31:0]      m_alu_res,
   input  logic [31:0]      m_mem_rdata,
   input  logic [2:0]       m_load_type,
   output logic             w_we,
   output logic [4:0]       w_a3,
   output logic [31:0]      w_wd,
   output logic [31:0]      w_pc,
   output logic             w_valid,
   output logic [CNT_W-1:0] w_retire_cnt
);

   logic             valid_q;
   logic [31:0]      pc_q;
   logic             reg_we_q;
   logic [4:0]       rd_q;
   logic [1:0]       wd_sel_q;
   logic [31:0]      alu_q;
   logic [31:0]      rdata_q;
   logic [2:0]       load_type_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      load_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         reg_we_q    <= 1'b0;
         rd_q        <= '0;
         wd_sel_q    <= '0;
         alu_q       <= '0;
         rdata_q     <= '0;
         load_type_q <= '0;
         cnt_q       <= '0;
      end else begin
         // An instruction retires when it leaves W, whether replaced or flushed.
         if (valid_q && (en || flush))
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (flush) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            reg_we_q    <= 1'b0;
            rd_q        <= '0;
            wd_sel_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            load_type_q <= '0;
         end else if (en) begin
            valid_q     <= m_valid;
            pc_q        <= m_pc;
            reg_we_q    <= m_reg_we;
            rd_q        <= m_rd;
            wd_sel_q    <= m_wd_sel;
            alu_q       <= m_alu_res;
            rdata_q     <= m_mem_rdata;
            load_type_q <= m_load_type;
         end
      end
   end

`ifdef WB_LOAD_EXT_EN
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      off     = alu_q[1:0];
      ld_byte = rdata_q[8*off +: 8];
      ld_half = rdata_q[16*off[1] +: 16];
      case (load_type_q)
         3'd1:    load_val = {24'b0, ld_byte};
         3'd2:    load_val = {{24{ld_byte[7]}}, ld_byte};
         3'd3:    load_val = {16'b0, ld_half};
         3'd4:    load_val = {{16{ld_half[15]}}, ld_half};
         default: load_val = rdata_q;
      endcase
   end
`else
   logic unused_load_type;
   assign unused_load_type = ^load_type_q;
   assign load_val         = rdata_q;
`endif

   always_comb begin
      case (wd_sel_q)
         2'd1:    w_wd = load_val;
         2'd2:    w_wd = pc_q + PC_LINK_OFS;
         default: w_wd = alu_q;
      endcase
   end

   assign w_we         = valid_q & reg_we_q & (rd_q != 5'd0);
   assign w_a3         = rd_q;
   assign w_pc         = pc_q;
   assign w_valid      = valid_q;
   assign w_retire_cnt = cnt_q;

endmodule

// File: tb/tb_mw_wb_stage.sv
// Scoreboard bench for mw_wb_stage; load expectations follow WB_LOAD_EXT_EN.
// A second instance with CNT_W=4 exercises retire-counter wrap.
module tb_mw_wb_stage;

   logic        clk = 1'b0;
   logic        reset, en, flush;
   logic        m_valid, m_reg_we;
   logic [31:0] m_pc, m_alu_res, m_mem_rdata;
   logic [4:0]  m_rd;
   logic [1:0]  m_wd_sel;
   logic [2:0]  m_load_type;
   logic        w_we, w_valid, w4_we, w4_valid;
   logic [4:0]  w_a3, w4_a3;
   logic [31:0] w_wd, w_pc, w4_wd, w4_pc, w_retire_cnt;
   logic [3:0]  w4_retire_cnt;

   typedef struct {
      logic        valid;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } wb_t;

   wb_t         sb[$];
   wb_t         cur;
   logic [31:0] exp_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mw_wb_stage dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_rd(m_rd),
      .m_wd_sel(m_wd_sel), .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata),
      .m_load_type(m_load_type),
      .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
      .w_valid(w_valid), .w_retire_cnt(w_retire_cnt));

   mw_wb_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_rd(m_rd),
      .m_wd_sel(m_wd_sel), .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata),
      .m_load_type(m_load_type),
      .w_we(w4_we), .w_a3(w4_a3), .w_wd(w4_wd), .w_pc(w4_pc),
      .w_valid(w4_valid), .w_retire_cnt(w4_retire_cnt));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] lt);
      m_valid = v; m_reg_we = we; m_rd = rd; m_wd_sel = sel;
      m_alu_res = alu; m_pc = pc; m_load_type = lt;
   endtask

   // Push the expected W state, advance one edge, then pop and compare.
   task automatic step(input string tag, input logic v, input logic we,
                       input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
      wb_t e, o;
      e.valid = v; e.we = we; e.a3 = a3; e.wd = wd; e.pc = pc;
      if (reset) exp_cnt = 0;
      else if (cur.valid && (en || flush)) exp_cnt = exp_cnt + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      cur = o;
      chk({tag, ".valid"}, {31'b0, w_valid}, {31'b0, o.valid});
      chk({tag, ".we"},    {31'b0, w_we},    {31'b0, o.we});
      chk({tag, ".a3"},    {27'b0, w_a3},    {27'b0, o.a3});
      chk({tag, ".wd"},    w_wd, o.wd);
      chk({tag, ".pc"},    w_pc, o.pc);
      chk({tag, ".cnt"},   w_retire_cnt, exp_cnt);
      chk({tag, ".cnt4"},  {28'b0, w4_retire_cnt}, {28'b0, exp_cnt[3:0]});
      chk({tag, ".wd4"},   w4_wd, o.wd);
   endtask

   task automatic hold(input string tag);
      step(tag, cur.valid, cur.we, cur.a3, cur.wd, cur.pc);
   endtask

   initial begin
      logic [31:0] lb3, lbu2, lh2, lhu0;
`ifdef WB_LOAD_EXT_EN
      lb3 = 32'hFFFF_FF80; lbu2 = 32'h0000_00FF; lh2 = 32'hFFFF_80FF; lhu0 = 32'h0000_7F01;
`else
      lb3 = 32'h80FF_7F01; lbu2 = 32'h80FF_7F01; lh2 = 32'h80FF_7F01; lhu0 = 32'h80FF_7F01;
`endif
      cur = '{default: '0};
      exp_cnt = 0;
      reset = 1; en = 1; flush = 0;
      drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom));
      m_mem_rdata = $urandom;
      step("rst0", 0, 0, 0, 0, 0);
      drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom));
      step("rst1", 0, 0, 0, 0, 0);

      reset = 0;
      drive(1, 1, 8, 0, 32'h1234_5678, 32'h3000, 0);
      step("alu", 1, 1, 8, 32'h1234_5678, 32'h3000);
      drive(1, 1, 0, 0, 32'h5, 32'h3004, 0);
      step("rd0", 1, 0, 0, 32'h5, 32'h3004);
      drive(1, 1, 31, 2, 32'h0, 32'h3010, 0);
      step("link", 1, 1, 31, 32'h3018, 32'h3010);

      m_mem_rdata = 32'h80FF_7F01;
      drive(1, 1, 9, 1, 32'h103, 32'h3020, 2);
      step("lb3", 1, 1, 9, lb3, 32'h3020);
      drive(1, 1, 9, 1, 32'h102, 32'h3024, 1);
      step("lbu2", 1, 1, 9, lbu2, 32'h3024);
      drive(1, 1, 9, 1, 32'h102, 32'h3028, 4);
      step("lh2", 1, 1, 9, lh2, 32'h3028);
      drive(1, 1, 9, 1, 32'h100, 32'h302C, 3);
      step("lhu0", 1, 1, 9, lhu0, 32'h302C);
      drive(1, 1, 9, 1, 32'h101, 32'h3030, 6);
      step("lw6", 1, 1, 9, 32'h80FF_7F01, 32'h3030);

      // Stall three cycles with the M inputs changing underneath.
      en = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 5'(i + 3), 0, $urandom, $urandom, 0);
         hold("stall");
      end
      flush = 1;
      step("flush", 0, 0, 0, 0, 0);
      flush = 0; en = 1;
      drive(1, 1, 4, 0, 32'hAA, 32'h3040, 0);
      step("refill", 1, 1, 4, 32'hAA, 32'h3040);
      flush = 1;
      drive(1, 1, 5, 0, 32'hBB, 32'h3044, 0);
      step("flush_en", 0, 0, 0, 0, 0);
      flush = 0;

      // Enough retirements to carry the 4-bit counter through zero.
      for (int i = 0; i < 17; i++) begin
         drive(1, 1, 5'(i + 1), 0, 32'(i), 32'h4000 + 32'(4 * i), 0);
         step("wrap", 1, 1, 5'(i + 1), 32'(i), 32'h4000 + 32'(4 * i));
      end
      chk("wrap_hit", {28'b0, w4_retire_cnt}, {28'b0, exp_cnt[3:0]});

      en = 0;
      hold("pre_rst");
      reset = 1;
      step("rst_stall", 0, 0, 0, 0, 0);
      reset = 0; en = 1;
      drive(1, 1, 7, 0, 32'h77, 32'h5000, 0);
      step("post_rst", 1, 1, 7, 32'h77, 32'h5000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
